// File: rtl/fast_memory_pkg.sv
// Shared encodings and helpers for the sized-access data RAM.
package fast_memory_pkg;

  // Access size encoding carried on req_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  // INIT sweeps FILL_WORD through memory; RUN serves requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of bytes touched by an access. The reserved size faults anyway;
  // it reports 4 only so the range check has a defined operand.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_nbytes = 3'd1;
      SIZE_HALF: size_nbytes = 3'd2;
      default:   size_nbytes = 3'd4;
    endcase
  endfunction

  // Natural alignment check: halves on even addresses, words on multiples of 4.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: size_misaligned = addr_lo[0];
      SIZE_WORD: size_misaligned = |addr_lo;
      default:   size_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational steering between right-justified CPU data and the four byte
// lanes of a memory word. Lane k always holds the byte at word address + k;
// endianness only decides which end of the CPU value that byte maps to.
module mem_lane_align
  import fast_memory_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] lane_rdata,
  output logic [3:0]  lane_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata
);

  logic [7:0] byte_sel;
  logic [7:0] half_lo_lane;
  logic [7:0] half_hi_lane;

  // Pick the addressed byte and the two lanes of the addressed halfword.
  always_comb begin
    byte_sel     = lane_rdata[8*addr_lo +: 8];
    half_lo_lane = lane_rdata[16*addr_lo[1] +: 8];
    half_hi_lane = lane_rdata[16*addr_lo[1] + 8 +: 8];
  end

  // Build lane enables, lane store data and the zero-extended load value.
  always_comb begin
    lane_en    = 4'b0000;
    lane_wdata = 32'h0;
    rdata      = 32'h0;
    case (size)
      SIZE_BYTE: begin
        lane_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = {24'h0, byte_sel};
      end
      SIZE_HALF: begin
        lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        if (BIG_ENDIAN != 0) begin
          // Lower address holds the most significant byte.
          lane_wdata = {2{wdata[7:0], wdata[15:8]}};
          rdata      = {16'h0, half_lo_lane, half_hi_lane};
        end else begin
          lane_wdata = {2{wdata[15:0]}};
          rdata      = {16'h0, half_hi_lane, half_lo_lane};
        end
      end
      SIZE_WORD: begin
        lane_en = 4'b1111;
        if (BIG_ENDIAN != 0) begin
          lane_wdata = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
          rdata      = {lane_rdata[7:0], lane_rdata[15:8], lane_rdata[23:16], lane_rdata[31:24]};
        end else begin
          lane_wdata = wdata;
          rdata      = lane_rdata;
        end
      end
      default: begin
        lane_en    = 4'b0000;
        lane_wdata = 32'h0;
        rdata      = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/sized_access_memory.sv
// Single-port byte-addressable data RAM with byte/half/word loads and stores.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only once the fill sweep is done.
// Every transferred request produces exactly one rsp_valid pulse in the next
// cycle, with no backpressure on the response side.
module sized_access_memory
  import fast_memory_pkg::*;
#(
  parameter int          NUM_OF_BYTES = 1024,
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] FILL_WORD    = 32'hE1A00000,
  parameter int          BIG_ENDIAN   = 0
) (
  input  logic                  clk,
  input  logic                  mem_reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  init_busy
);

  localparam int NUM_WORDS = NUM_OF_BYTES / 4;
  localparam int WIDX_W    = $clog2(NUM_WORDS);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] MEM_END = (ADDR_WIDTH+1)'(NUM_OF_BYTES);

  // The fill word laid out in lanes so that a word load returns FILL_WORD
  // whatever the endianness.
  localparam logic [31:0] FILL_LANES = (BIG_ENDIAN != 0) ?
    {FILL_WORD[7:0], FILL_WORD[15:8], FILL_WORD[23:16], FILL_WORD[31:24]} : FILL_WORD;

  state_e            state;
  logic [WIDX_W-1:0] widx;

  logic              accept;
  logic              fault;
  logic [ADDR_WIDTH:0] end_addr;
  logic [WIDX_W-1:0] req_widx;
  logic [WIDX_W-1:0] mem_widx;
  logic [31:0]       mem_wlanes;
  logic [3:0]        mem_we;
  logic [31:0]       lane_rdata;
  logic [3:0]        lane_en;
  logic [31:0]       lane_wdata;
  logic [31:0]       align_rdata;

  assign req_ready = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);
  assign accept    = req_valid & req_ready;
  assign req_widx  = req_addr[WIDX_W+1:2];

  // Legality check; the end address is one bit wider so high addresses cannot wrap.
  always_comb begin
    end_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(size_nbytes(req_size));
    fault    = (req_size == SIZE_RSVD) ||
               size_misaligned(req_size, req_addr[1:0]) ||
               (end_addr > MEM_END);
  end

  // Write port: the fill sweep owns it in INIT, legal stores in RUN.
  always_comb begin
    mem_widx   = req_widx;
    mem_wlanes = lane_wdata;
    mem_we     = 4'b0000;
    if (state == ST_INIT) begin
      mem_widx   = widx;
      mem_wlanes = FILL_LANES;
      mem_we     = 4'b1111;
    end else if (accept && req_write && !fault) begin
      mem_we = lane_en;
    end
    if (!mem_reset_n) begin
      mem_we = 4'b0000;
    end
  end

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .wdata      (req_wdata),
    .lane_rdata (lane_rdata),
    .lane_en    (lane_en),
    .lane_wdata (lane_wdata),
    .rdata      (align_rdata)
  );

  // Four independent byte-lane arrays, each with its own write enable.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] lane_mem [NUM_WORDS];

    // Commit one byte lane on a write edge.
    always_ff @(posedge clk) begin
      if (mem_we[k]) begin
        lane_mem[mem_widx] <= mem_wlanes[8*k +: 8];
      end
    end

    assign lane_rdata[8*k +: 8] = lane_mem[req_widx];
  end

  // Init/run sequencing and the registered one-cycle response.
  always_ff @(posedge clk) begin
    if (!mem_reset_n) begin
      state     <= ST_INIT;
      widx      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_fault <= accept & fault;
      rsp_rdata <= (accept && !req_write && !fault) ? align_rdata : 32'h0;
      if (state == ST_INIT) begin
        if (widx == LAST_IDX) begin
          widx  <= '0;
          state <= ST_RUN;
        end else begin
          widx <= widx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sized_access_memory.sv
// Directed bench for sized_access_memory: a little-endian and a big-endian
// instance share the request inputs; expected values are hand-computed.
module tb_sized_access_memory;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;
  localparam logic [31:0] FILL = 32'hE1A00000;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic mem_reset_n = 1'b0;

  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size  = 2'b00;
  logic [31:0] req_wdata = 32'h0;

  logic        req_ready, rsp_valid, rsp_fault, init_busy;
  logic [31:0] rsp_rdata;
  logic        be_req_ready, be_rsp_valid, be_rsp_fault, be_init_busy;
  logic [31:0] be_rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  sized_access_memory #(
    .NUM_OF_BYTES(1024), .ADDR_WIDTH(32), .FILL_WORD(FILL), .BIG_ENDIAN(0)
  ) dut (
    .clk(clk), .mem_reset_n(mem_reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .init_busy(init_busy)
  );

  sized_access_memory #(
    .NUM_OF_BYTES(1024), .ADDR_WIDTH(32), .FILL_WORD(FILL), .BIG_ENDIAN(1)
  ) dut_be (
    .clk(clk), .mem_reset_n(mem_reset_n), .req_valid(req_valid), .req_ready(be_req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(be_rsp_valid), .rsp_rdata(be_rsp_rdata), .rsp_fault(be_rsp_fault), .init_busy(be_init_busy)
  );

  // Driver: one request, response captured at the following negedge.
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                        input logic [31:0] wd, output logic vld, output logic flt,
                        output logic [31:0] rd, output logic [31:0] rd_be);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_size  = sz;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vld   = rsp_valid;
    flt   = rsp_fault;
    rd    = rsp_rdata;
    rd_be = be_rsp_rdata;
  endtask

  // Releases a held reset at a negedge and counts busy cycles (bounded).
  task automatic release_and_count(input string name);
    int n = 0;
    int ready_bad = 0;
    @(negedge clk);
    mem_reset_n = 1'b1;
    while (init_busy && n < 1000) begin
      if (req_ready || be_req_ready) ready_bad++;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d expected 256", name, n);
    end
    vectors++;
    if (ready_bad !== 0 || req_ready !== 1'b1 || be_init_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready: ready during init %0d, ready after %b be_busy %b expected 0/1/0",
               name, ready_bad, req_ready, be_init_busy);
    end
  endtask

  task automatic test_reset();
    logic vld, flt;
    logic [31:0] rd, rdb;
    mem_reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (init_busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy %b ready %b vld %b flt %b rd %h expected 1 0 0 0 00000000",
               init_busy, req_ready, rsp_valid, rsp_fault, rsp_rdata);
    end
    release_and_count("reset");
    do_req(32'h10, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (vld !== 1'b1 || flt !== 1'b0 || rd !== FILL) begin
      miscompares++;
      $display("FAIL init_fill_load: vld %b flt %b rd %h expected 1 0 %h", vld, flt, rd, FILL);
    end
  endtask

  task automatic test_endian();
    logic vld, flt;
    logic [31:0] rd, rdb;
    do_req(32'h20, 1'b1, SZ_W, 32'h11223344, vld, flt, rd, rdb);
    vectors++;
    if (vld !== 1'b1 || flt !== 1'b0 || rd !== 32'h0 || rdb !== 32'h0) begin
      miscompares++;
      $display("FAIL store_rsp: vld %b flt %b rd %h be %h expected 1 0 0 0", vld, flt, rd, rdb);
    end
    do_req(32'h21, 1'b0, SZ_B, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== 32'h00000033 || flt !== 1'b0) begin
      miscompares++;
      $display("FAIL le_byte_0x21: got %h flt %b expected 00000033 0", rd, flt);
    end
    vectors++;
    if (rdb !== 32'h00000022) begin
      miscompares++;
      $display("FAIL be_byte_0x21: got %h expected 00000022", rdb);
    end
    do_req(32'h22, 1'b0, SZ_H, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== 32'h00001122) begin
      miscompares++;
      $display("FAIL le_half_0x22: got %h expected 00001122", rd);
    end
    vectors++;
    if (rdb !== 32'h00003344) begin
      miscompares++;
      $display("FAIL be_half_0x22: got %h expected 00003344", rdb);
    end
    do_req(32'h20, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== 32'h11223344 || rdb !== 32'h11223344) begin
      miscompares++;
      $display("FAIL word_0x20: le %h be %h expected 11223344", rd, rdb);
    end
  endtask

  task automatic test_partial_store();
    logic vld, flt;
    logic [31:0] rd, rdb;
    do_req(32'h40, 1'b1, SZ_B, 32'hFFFFFFAB, vld, flt, rd, rdb);
    do_req(32'h40, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== 32'hE1A000AB) begin
      miscompares++;
      $display("FAIL byte_store_merge: got %h expected e1a000ab", rd);
    end
    do_req(32'h42, 1'b1, SZ_H, 32'hFFFF5566, vld, flt, rd, rdb);
    do_req(32'h40, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== 32'h556600AB) begin
      miscompares++;
      $display("FAIL half_store_merge: got %h expected 556600ab", rd);
    end
  endtask

  task automatic test_faults();
    logic vld, flt;
    logic [31:0] rd, rdb;
    do_req(32'h3FE, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (vld !== 1'b1 || flt !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL fault_word_0x3fe: vld %b flt %b rd %h expected 1 1 0", vld, flt, rd);
    end
    do_req(32'h3FE, 1'b0, SZ_H, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b0 || rd !== 32'h0000E1A0) begin
      miscompares++;
      $display("FAIL top_half_0x3fe: flt %b rd %h expected 0 0000e1a0", flt, rd);
    end
    do_req(32'h101, 1'b1, SZ_H, 32'h0000BEEF, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL fault_half_store_0x101: flt %b rd %h expected 1 0", flt, rd);
    end
    do_req(32'h100, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== FILL) begin
      miscompares++;
      $display("FAIL reread_0x100: got %h expected %h", rd, FILL);
    end
    do_req(32'h40, 1'b0, SZ_R, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL fault_rsvd_load: flt %b rd %h expected 1 0", flt, rd);
    end
    do_req(32'h60, 1'b1, SZ_R, 32'h12345678, vld, flt, rd, rdb);
    do_req(32'h60, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (rd !== FILL) begin
      miscompares++;
      $display("FAIL rsvd_store_no_write: got %h expected %h", rd, FILL);
    end
    do_req(32'hFFFFFFFC, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL fault_wrap_0xfffffffc: flt %b rd %h expected 1 0", flt, rd);
    end
    do_req(32'h400, 1'b1, SZ_W, 32'hCAFEF00D, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_store_0x400: flt %b expected 1", flt);
    end
    do_req(32'h3FC, 1'b1, SZ_W, 32'hA5A55A5A, vld, flt, rd, rdb);
    do_req(32'h3FC, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (flt !== 1'b0 || rd !== 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL last_word_0x3fc: flt %b rd %h expected 0 a5a55a5a", flt, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t [8];
    logic        w_t [8];
    logic [1:0]  s_t [8];
    logic [31:0] d_t [8];
    logic [31:0] e_t [8];
    logic        f_t [8];
    logic [31:0] exp_q [$];
    logic [31:0] exp_d;
    int pulses = 0;
    a_t = '{32'h80, 32'h80, 32'h84, 32'h84, 32'h86, 32'h84, 32'h80, 32'h80};
    w_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    s_t = '{SZ_W, SZ_W, SZ_B, SZ_B, SZ_H, SZ_W, SZ_R, SZ_W};
    d_t = '{32'hDEADBEEF, 32'h0, 32'h00000012, 32'h0, 32'h0000CAFE, 32'h0, 32'h0, 32'h0};
    e_t = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h00000012, 32'h0, 32'hCAFE0012, 32'h0, 32'hDEADBEEF};
    f_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_d = exp_q.pop_front();
        if (rsp_valid === 1'b1) pulses++;
        vectors++;
        if (rsp_rdata !== exp_d || rsp_fault !== f_t[i-1]) begin
          miscompares++;
          $display("FAIL b2b_rsp%0d: rd %h flt %b expected %h %b", i-1, rsp_rdata, rsp_fault, exp_d, f_t[i-1]);
        end
      end
      if (i < 8) begin
        req_valid = 1'b1;
        req_addr  = a_t[i];
        req_write = w_t[i];
        req_size  = s_t[i];
        req_wdata = d_t[i];
        exp_q.push_back(e_t[i]);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (pulses !== 8 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d then vld %b expected 8 then 0", pulses, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    logic vld, flt;
    logic [31:0] rd, rdb;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h80;
    req_write = 1'b0;
    req_size  = SZ_W;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    mem_reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: vld %b busy %b ready %b expected 0 1 0", rsp_valid, init_busy, req_ready);
    end
    release_and_count("rerun");
    do_req(32'h80, 1'b0, SZ_W, 32'h0, vld, flt, rd, rdb);
    vectors++;
    if (vld !== 1'b1 || rd !== FILL || rdb !== FILL) begin
      miscompares++;
      $display("FAIL refill_0x80: vld %b le %h be %h expected 1 %h", vld, rd, rdb, FILL);
    end
  endtask

  initial begin
    test_reset();
    test_endian();
    test_partial_store();
    test_faults();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
